dadda_product_accumulator: RTL and testbench
============================================

// Module: dadda_product_accumulator
// PURPOSE
//  Downstream stage of the combinational 16x16 Dadda multiplier (DADDA_16x16_42).
//  Sums a frame of unsigned 32-bit products into a wide accumulator; a frame ends on in_last or at MAX_LEN.
//  Holds the frame result in an output register behind a valid/ready handshake.
//  Back-pressures the multiplier's operand source.
// PARAMETERS
//  PROD_W   32   product width; matches multiplier out = 2*BIT
//  ACC_W    40   accumulator width; 8 guard bits
//  CNT_W    8    width of the frame product counter
//  MAX_LEN  255  products per frame before a forced close (1..2^CNT_W-1)
// PORTS
//  clock        in   1       single clock; all state updates on posedge
//  reset_n      in   1       synchronous, active-low reset
//  in_valid     in   1       in_product/in_last valid this cycle
//  in_ready     out  1       stage can accept a product this cycle
//  in_product   in   PROD_W  unsigned product from multiplier
//  in_last      in   1       final product of the frame
//  out_valid    out  1       out_* hold a finished frame
//  out_ready    in   1       consumer accepts the frame
//  out_sum      out  ACC_W   frame sum, modulo 2^ACC_W
//  out_count    out  CNT_W   number of products in the frame (>=1)
//  out_overflow out  1       sticky: carry out of ACC_W occurred during the frame
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    - state=IDLE; acc=0, cnt=0, ovf=0.
//    - in_ready=0 during reset; out_valid=0, out_sum=0, out_count=0, out_overflow=0.
//    - Reset mid-frame or mid-HOLD discards everything; nothing is emitted.
//  - Accept = in_valid & in_ready.
//    - in_ready = 1 in IDLE/ACCUM, 0 in HOLD (no bypass path).
//    - in_ready is a registered function of state only, never of in_valid.
//  - FSM transitions on accept:
//    - IDLE: non-last accept -> acc=in_product, cnt=1, ovf=0 -> ACCUM.
//    - IDLE: last accept -> load output directly with sum=in_product, count=1 -> HOLD.
//    - ACCUM: {c,s} = acc + zero_ext(in_product); ovf |= c; cnt += 1.
//    - ACCUM: close if in_last OR new cnt==MAX_LEN -> load out_* with s, cnt, ovf|c -> HOLD.
//    - ACCUM: otherwise acc=s, stay in ACCUM.
//    - HOLD: out_valid=1; out_* stable until out_ready.
//    - HOLD + out_ready: next cycle out_valid=0; acc=0, cnt=0, ovf=0 -> IDLE.
//      out_* keep their last values (don't-care when !out_valid).
//  - Latency: last product accepted at edge N -> out_valid=1 after edge N.
//  - Throughput: one product/cycle while accumulating; 1-cycle bubble per frame (HOLD) minimum.
//  - No accept in IDLE/ACCUM: state unchanged, no idle timeout.
//  - in_last with in_valid=0 is ignored.
//  - Forced close at MAX_LEN: next accepted product opens a new frame; in_last need not be seen.
//  - Overflow: sum wraps mod 2^ACC_W; out_overflow reports it.
//    With defaults, overflow needs more than 2^8 max-value products, so it is unreachable.
//    Bench must use ACC_W=33 to exercise it.
//  - out_valid=0 with out_ready=1 has no effect.
// STRUCTURE
//  - Shared package dadda_pkg holds:
//    - localparams BIT=16, PROD_W=2*BIT;
//    - state enum {IDLE, ACCUM, HOLD} (2-bit encoding);
//    - ACC_W default.
//  - Single module: one FSM, one ACC_W+1-bit adder, output register bank. No sub-module needed.
//  - Multiplier is instantiated by the parent, not here.
// TESTING (bench drives multiplier out -> in_product; checks at posedge; golden model in bench)
//  1. Reset then idle:
//     reset_n=0 for 2 cycles -> out_valid=0, in_ready=0 in reset; in_ready=1 the cycle after release.
//  2. Single-product frame:
//     in_product=0x0000_FFFE (2*32767), in_last=1 -> next cycle out_valid=1,
//     out_sum=0xFFFE, out_count=1, out_overflow=0.
//  3. Back-to-back frame of 4:
//     products 65535*65535=0xFFFE0001 x4, last on 4th, out_ready=1 ->
//     out_sum=0x3_FFF8_0004, out_count=4; in_ready=0 for exactly 1 cycle.
//  4. Back-pressure:
//     hold out_ready=0 for 5 cycles in HOLD -> out_* stable, in_ready=0,
//     in_valid pulses not counted; release -> IDLE next cycle.
//  5. Forced close, MAX_LEN=3, no in_last:
//     products 1,2,3,4 -> frame {sum=6,count=3}; product 4 starts a new frame.
//  6. Overflow (ACC_W=33) and reset mid-frame:
//     3x0xFFFFFFFF, last -> out_sum=0x0_FFFF_FFFD, out_overflow=1.
//     Then 2 products, then reset_n=0 -> no out_valid; the next frame's sum excludes them.

Source files
------------

// File: rtl/dadda_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dadda_pkg : shared constants and FSM state type for the Dadda datapath   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package dadda_pkg;
   localparam int BIT           = 16;
   localparam int PROD_W        = 2 * BIT;
   localparam int ACC_W_DEFAULT = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;
endpackage
`default_nettype wire

// File: rtl/dadda_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dadda_product_accumulator : sums product frames into a held output reg   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dadda_product_accumulator #(
   parameter int PROD_W  = dadda_pkg::PROD_W,
   parameter int ACC_W   = dadda_pkg::ACC_W_DEFAULT,
   parameter int CNT_W   = 8,
   parameter int MAX_LEN = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_overflow
);
   import dadda_pkg::state_t;
   import dadda_pkg::IDLE;
   import dadda_pkg::ACCUM;
   import dadda_pkg::HOLD;

   localparam logic [CNT_W-1:0] C_MAX_LEN  = CNT_W'(MAX_LEN);
   localparam logic             C_ONE_SHOT = (MAX_LEN == 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             r_ready;

   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_accept;
   logic             w_close;

   assign in_ready  = r_ready;
   assign w_accept  = in_valid & r_ready;
   assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(in_product);
   assign w_carry   = w_sum[ACC_W];
   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_close      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_close      = in_last | C_ONE_SHOT;
               w_state_next = w_close ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (w_accept) begin
               w_close      = in_last | (w_cnt_inc == C_MAX_LEN);
               w_state_next = w_close ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_ovf        <= 1'b0;
         r_ready      <= 1'b0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Ready is registered from the next state so it never depends on in_valid.
         r_ready <= (w_state_next != HOLD);
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_close) begin
                     out_valid    <= 1'b1;
                     out_sum      <= ACC_W'(in_product);
                     out_count    <= CNT_W'(1);
                     out_overflow <= 1'b0;
                  end else begin
                     r_acc <= ACC_W'(in_product);
                     r_cnt <= CNT_W'(1);
                     r_ovf <= 1'b0;
                  end
               end
            end
            ACCUM: begin
               if (w_accept) begin
                  if (w_close) begin
                     out_valid    <= 1'b1;
                     out_sum      <= w_sum[ACC_W-1:0];
                     out_count    <= w_cnt_inc;
                     out_overflow <= r_ovf | w_carry;
                  end else begin
                     r_acc <= w_sum[ACC_W-1:0];
                     r_cnt <= w_cnt_inc;
                     r_ovf <= r_ovf | w_carry;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_ovf     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dadda_product_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dadda_product_accumulator : three parameterisations vs. a frame model |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_dadda_product_accumulator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld  [3];
   logic        lst  [3];
   logic        ordy [3];
   logic [31:0] prod [3];
   logic        ir   [3];
   logic        ov   [3];
   logic        oovf [3];
   logic [7:0]  ocnt [3];
   logic [39:0] sum_a;
   logic [39:0] sum_b;
   logic [32:0] sum_c;

   int n_vec  = 0;
   int n_fail = 0;

   // Instance 0: defaults; 1: MAX_LEN=3; 2: ACC_W=33 for overflow.
   int unsigned maxlen [3] = '{255, 3, 255};
   int unsigned accw   [3] = '{40, 40, 33};

   bit              m_hold  [3];
   bit              m_ready [3];
   bit              m_ov    [3];
   longint unsigned m_tot   [3];
   int unsigned     m_n     [3];
   longint unsigned m_osum  [3];
   int unsigned     m_ocnt  [3];
   bit              m_oovf  [3];

   always #5 clk = ~clk;

   dadda_product_accumulator u_a (
      .clock(clk), .reset_n(rst_n), .in_valid(vld[0]), .in_ready(ir[0]),
      .in_product(prod[0]), .in_last(lst[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_sum(sum_a), .out_count(ocnt[0]), .out_overflow(oovf[0]));

   dadda_product_accumulator #(.MAX_LEN(3)) u_b (
      .clock(clk), .reset_n(rst_n), .in_valid(vld[1]), .in_ready(ir[1]),
      .in_product(prod[1]), .in_last(lst[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_sum(sum_b), .out_count(ocnt[1]), .out_overflow(oovf[1]));

   dadda_product_accumulator #(.ACC_W(33)) u_c (
      .clock(clk), .reset_n(rst_n), .in_valid(vld[2]), .in_ready(ir[2]),
      .in_product(prod[2]), .in_last(lst[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_sum(sum_c), .out_count(ocnt[2]), .out_overflow(oovf[2]));

   function automatic logic [63:0] get_sum(input int i);
      case (i)
         0:       return 64'(sum_a);
         1:       return 64'(sum_b);
         default: return 64'(sum_c);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: true running sum, truncated only when a frame is emitted.
   task automatic model_edge(input int i);
      if (!rst_n) begin
         m_hold[i] = 0; m_ready[i] = 0; m_ov[i] = 0; m_tot[i] = 0; m_n[i] = 0;
         m_osum[i] = 0; m_ocnt[i] = 0; m_oovf[i] = 0;
      end else if (m_hold[i]) begin
         if (ordy[i]) begin
            m_hold[i] = 0;
            m_ov[i]   = 0;
         end
         m_ready[i] = !m_hold[i];
      end else begin
         if (vld[i] && m_ready[i]) begin
            m_tot[i] += longint'(prod[i]);
            m_n[i]++;
            if (lst[i] || m_n[i] == maxlen[i]) begin
               m_hold[i] = 1;
               m_ov[i]   = 1;
               m_osum[i] = m_tot[i] % (64'd1 << accw[i]);
               m_ocnt[i] = m_n[i];
               m_oovf[i] = (m_tot[i] >> accw[i]) != 0;
               m_tot[i]  = 0;
               m_n[i]    = 0;
            end
         end
         m_ready[i] = !m_hold[i];
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(m_ov[i]));
         chk($sformatf("u%0d.in_ready", i), 64'(ir[i]), 64'(m_ready[i]));
         if (m_ov[i] || !rst_n) begin
            chk($sformatf("u%0d.out_sum", i), get_sum(i), m_osum[i]);
            chk($sformatf("u%0d.out_count", i), 64'(ocnt[i]), 64'(m_ocnt[i]));
            chk($sformatf("u%0d.out_overflow", i), 64'(oovf[i]), 64'(m_oovf[i]));
         end
      end
   endtask

   task automatic push(input int i, input logic [31:0] p, input logic last);
      for (int k = 0; k < 20 && !m_ready[i]; k++) step();
      n_vec++;
      assert (m_ready[i]) else begin
         n_fail++;
         $error("FAIL u%0d.push_timeout observed=%0d expected=%0d", i, m_ready[i], 1);
      end
      vld[i] = 1; prod[i] = p; lst[i] = last;
      step();
      vld[i] = 0; lst[i] = 0;
   endtask

   logic [63:0] held_sum;

   initial begin
      for (int i = 0; i < 3; i++) begin
         vld[i] = 0; lst[i] = 0; ordy[i] = 1; prod[i] = '0;
      end

      // Reset, then ready one cycle after release.
      rst_n = 0;
      step();
      step();
      rst_n = 1;
      step();
      chk("ready_after_reset", 64'(ir[0]), 64'd1);

      // Single-product frame.
      push(0, 32'h0000_FFFE, 1);
      chk("single_valid", 64'(ov[0]), 64'd1);
      chk("single_sum", 64'(sum_a), 64'h0000_FFFE);
      chk("single_count", 64'(ocnt[0]), 64'd1);
      step();

      // Back-to-back frame of four max products.
      for (int k = 0; k < 4; k++) push(0, 32'hFFFE_0001, k == 3);
      chk("b2b_sum", 64'(sum_a), 64'h3_FFF8_0004);
      chk("b2b_count", 64'(ocnt[0]), 64'd4);
      chk("b2b_ready_low", 64'(ir[0]), 64'd0);
      step();
      chk("b2b_ready_back", 64'(ir[0]), 64'd1);

      // Back-pressure: output held, stray valids ignored.
      ordy[0] = 0;
      push(0, 32'd100, 0);
      push(0, 32'd23, 1);
      held_sum = 64'(sum_a);
      chk("bp_sum", held_sum, 64'd123);
      for (int k = 0; k < 5; k++) begin
         vld[0] = k[0]; prod[0] = $urandom; lst[0] = 1;
         step();
         chk("bp_stable", 64'(sum_a), held_sum);
      end
      vld[0] = 0; lst[0] = 0; ordy[0] = 1;
      step();
      chk("bp_released", 64'(ov[0]), 64'd0);

      // Forced close at MAX_LEN=3.
      push(1, 32'd1, 0);
      push(1, 32'd2, 0);
      push(1, 32'd3, 0);
      chk("forced_sum", 64'(sum_b), 64'd6);
      chk("forced_count", 64'(ocnt[1]), 64'd3);
      push(1, 32'd4, 0);
      push(1, 32'd5, 1);
      chk("forced_next_sum", 64'(sum_b), 64'd9);
      chk("forced_next_count", 64'(ocnt[1]), 64'd2);
      step();

      // Overflow with ACC_W=33, then reset mid-frame.
      for (int k = 0; k < 3; k++) push(2, 32'hFFFF_FFFF, k == 2);
      chk("ovf_sum", 64'(sum_c), 64'h0_FFFF_FFFD);
      chk("ovf_flag", 64'(oovf[2]), 64'd1);
      step();
      push(2, $urandom, 0);
      push(2, $urandom, 0);
      rst_n = 0;
      step();
      rst_n = 1;
      step();
      chk("rst_no_valid", 64'(ov[2]), 64'd0);
      push(2, 32'd7, 1);
      chk("rst_fresh_sum", 64'(sum_c), 64'd7);
      chk("rst_fresh_ovf", 64'(oovf[2]), 64'd0);
      step();

      // Randomized traffic on all three instances.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            vld[i]  = ($urandom_range(0, 3) != 0);
            prod[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            lst[i]  = ($urandom_range(0, 4) == 0);
            ordy[i] = ($urandom_range(0, 2) != 0);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
